// File: rtl/ghash_pkg.sv
// ---------------------------------------------------------------------------
// ghash_pkg
//   Shared definitions for the GHASH sequencer of the AES-GCM core:
//   block/length widths, the controller state encoding, and the helper that
//   turns a bit length into a count of 128-bit blocks.
// ---------------------------------------------------------------------------
package ghash_pkg;

  localparam int GHASH_BLK_W = 128;
  localparam int LEN_W       = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_AAD       = 3'd1,
    ST_CT        = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT      = 3'd4,
    ST_LEN_ISSUE = 3'd5,
    ST_LEN_WAIT  = 3'd6
  } ghState_e;

  // ceil(lenBits / 128). The sum is one bit wider so a length near 2^64
  // cannot wrap before the shift.
  function automatic logic [LEN_W-1:0] lenToBlocks(input logic [LEN_W-1:0] lenBits);
    logic [LEN_W:0] padded;
    padded = {1'b0, lenBits} + (LEN_W+1)'(GHASH_BLK_W - 1);
    return LEN_W'(padded >> $clog2(GHASH_BLK_W));
  endfunction

endpackage

// File: rtl/ghash_blk_counter.sv
// ---------------------------------------------------------------------------
// ghash_blk_counter
//   Loadable down-counter of blocks still expected in one message phase.
//   Ports:
//     iClk, iRst  clock, synchronous active-high reset (count -> 0)
//     iLoad       load iLoadVal (has priority over iDec)
//     iLoadVal    block count for the phase
//     iDec        one block consumed; saturates at zero
//     oZero       no blocks left in this phase
// ---------------------------------------------------------------------------
module ghash_blk_counter
  import ghash_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iLoad,
  input  logic [CNT_W-1:0] iLoadVal,
  input  logic             iDec,
  output logic             oZero
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its inputs, independent of block evaluation order.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      count <= '0;
    end else if (iLoad) begin
      count <= iLoadVal;
    end else if (iDec && !oZero) begin
      count <= count - CNT_W'(1);
    end
  end

  assign oZero = (count == '0);

endmodule

// File: rtl/ghash_ctrl.sv
// ---------------------------------------------------------------------------
// ghash_ctrl
//   Sequencer for the GHASH datapath. Accepts zero-padded AAD then ciphertext
//   blocks, issues each block with the running hash Y to the external
//   multiplier, folds the product back into Y, then appends the GCM length
//   block and presents the final hash S.
//   Ports:
//     iClk, iRst             clock, synchronous active-high reset
//     iHashkey_valid         H loaded in the datapath (sticky until reset)
//     iStart, iAad_len,
//     iCt_len                message start and bit lengths (IDLE only)
//     iBlock, iBlock_valid,
//     oBlock_ready           upstream block handshake
//     oPhase_ct              0 = AAD expected, 1 = ciphertext phase
//     oGh_ctext, oGh_y,
//     oGh_ctext_valid,
//     oGh_next               operands and start pulse to the multiplier
//     iGh_y, iGh_y_valid     multiplier product (X ^ Y) * H
//     oBusy                  controller outside IDLE
//     oTag_hash, oTag_valid  final S and its one-cycle strobe
//   Block vectors are [0:127]: bit 0 is the GCM most significant bit.
// ---------------------------------------------------------------------------
module ghash_ctrl
  import ghash_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iHashkey_valid,
  input  logic                   iStart,
  input  logic [LEN_W-1:0]       iAad_len,
  input  logic [LEN_W-1:0]       iCt_len,
  input  logic [0:GHASH_BLK_W-1] iBlock,
  input  logic                   iBlock_valid,
  output logic                   oBlock_ready,
  output logic                   oPhase_ct,
  output logic [0:GHASH_BLK_W-1] oGh_ctext,
  output logic [0:GHASH_BLK_W-1] oGh_y,
  output logic                   oGh_ctext_valid,
  output logic                   oGh_next,
  input  logic [0:GHASH_BLK_W-1] iGh_y,
  input  logic                   iGh_y_valid,
  output logic                   oBusy,
  output logic [0:GHASH_BLK_W-1] oTag_hash,
  output logic                   oTag_valid
);

  ghState_e               state;
  ghState_e               stateNext;
  logic                   keyLoaded;
  logic [LEN_W-1:0]       aadLenQ;
  logic [LEN_W-1:0]       ctLenQ;
  logic [0:GHASH_BLK_W-1] yQ;

  logic [CNT_W-1:0]       nAad;
  logic [CNT_W-1:0]       nCt;
  logic                   aadZero;
  logic                   ctZero;

  logic                   startAcc;
  logic                   blockAcc;
  logic                   prodAcc;
  logic                   lenAcc;
  logic                   lastProd;
  logic                   emptyMsg;

  assign nAad = CNT_W'(lenToBlocks(iAad_len));
  assign nCt  = CNT_W'(lenToBlocks(iCt_len));

  assign startAcc = (state == ST_IDLE) && iStart && keyLoaded;
  assign blockAcc = oBlock_ready && iBlock_valid;
  // Products arriving in any other state (e.g. in flight across a reset)
  // are dropped here rather than filtered upstream.
  assign prodAcc  = (state == ST_WAIT) && iGh_y_valid;
  // During the tag strobe cycle the FSM still sits in LEN_WAIT; a second
  // valid in that cycle must not re-capture S.
  assign lenAcc   = (state == ST_LEN_WAIT) && iGh_y_valid && !oTag_valid;
  assign lastProd = aadZero && ctZero;
  assign emptyMsg = (nAad == '0) && (nCt == '0);

  ghash_blk_counter #(.CNT_W(CNT_W)) u_aad_cnt (
    .iClk     (iClk),
    .iRst     (iRst),
    .iLoad    (startAcc),
    .iLoadVal (nAad),
    .iDec     (blockAcc && (state == ST_AAD)),
    .oZero    (aadZero)
  );

  ghash_blk_counter #(.CNT_W(CNT_W)) u_ct_cnt (
    .iClk     (iClk),
    .iRst     (iRst),
    .iLoad    (startAcc),
    .iLoadVal (nCt),
    .iDec     (blockAcc && (state == ST_CT)),
    .oZero    (ctZero)
  );

  // NOTE: stateNext gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE: begin
        if (startAcc) begin
          if (nAad != '0)     stateNext = ST_AAD;
          else if (nCt != '0) stateNext = ST_CT;
          else                stateNext = ST_LEN_ISSUE;
        end
      end
      ST_AAD, ST_CT: begin
        if (iBlock_valid) stateNext = ST_ISSUE;
      end
      ST_ISSUE: stateNext = ST_WAIT;
      ST_WAIT: begin
        if (iGh_y_valid) begin
          if (!aadZero)     stateNext = ST_AAD;
          else if (!ctZero) stateNext = ST_CT;
          else              stateNext = ST_LEN_ISSUE;
        end
      end
      ST_LEN_ISSUE: stateNext = ST_LEN_WAIT;
      // Stay one extra cycle so the tag strobe coincides with a busy state.
      ST_LEN_WAIT: begin
        if (oTag_valid) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Operand registers double as the issue outputs: they are loaded on the
  // edge that enters an issue state, so they are valid during the issue
  // cycle and simply hold afterwards.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      keyLoaded  <= 1'b0;
      aadLenQ    <= '0;
      ctLenQ     <= '0;
      yQ         <= '0;
      oGh_ctext  <= '0;
      oGh_y      <= '0;
      oTag_hash  <= '0;
      oTag_valid <= 1'b0;
    end else begin
      oTag_valid <= 1'b0;

      if (iHashkey_valid) begin
        keyLoaded <= 1'b1;
      end

      if (startAcc) begin
        aadLenQ <= iAad_len;
        ctLenQ  <= iCt_len;
        yQ      <= '0;
        // Zero-length message goes straight to the length block with Y = 0.
        if (emptyMsg) begin
          oGh_ctext <= {iAad_len, iCt_len};
          oGh_y     <= '0;
        end
      end

      if (blockAcc) begin
        oGh_ctext <= iBlock;
        oGh_y     <= yQ;
      end

      if (prodAcc) begin
        yQ <= iGh_y;
        // Final data product: the length block is issued next cycle and
        // must already see the new Y.
        if (lastProd) begin
          oGh_ctext <= {aadLenQ, ctLenQ};
          oGh_y     <= iGh_y;
        end
      end

      if (lenAcc) begin
        oTag_hash  <= iGh_y;
        oTag_valid <= 1'b1;
      end
    end
  end

  assign oBlock_ready    = (state == ST_AAD) || (state == ST_CT);
  assign oGh_next        = (state == ST_ISSUE) || (state == ST_LEN_ISSUE);
  assign oGh_ctext_valid = oGh_next;
  assign oBusy           = (state != ST_IDLE);
  // Once the AAD counter has drained the message is in its ciphertext phase,
  // including the issue/wait cycles of the last AAD block.
  assign oPhase_ct       = (state != ST_IDLE) && aadZero;

endmodule
